// File: rtl/slow_clock.sv
// Divides clk down to two free-running 50%-duty clocks (clk_10, clk_400) using
// independent half-period counters. Define SLOW_CLOCK_TICK_EN to add rising-edge tick outputs.
`timescale 1ns/1ps
module slow_clock #(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned FAST_FREQ_HZ = 10_000_000,
  parameter int unsigned SCL_FREQ_HZ  = 400_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_400,
  output logic clk_10
`ifdef SLOW_CLOCK_TICK_EN
  ,
  output logic tick_10,
  output logic tick_400
`endif
);

  localparam int unsigned HALF_10  = CLK_FREQ_HZ / (2 * FAST_FREQ_HZ);
  localparam int unsigned HALF_400 = CLK_FREQ_HZ / (2 * SCL_FREQ_HZ);
  localparam int unsigned W_10     = (HALF_10  > 1) ? $clog2(HALF_10)  : 1;
  localparam int unsigned W_400    = (HALF_400 > 1) ? $clog2(HALF_400) : 1;
  localparam logic [W_10-1:0]  LAST_10  = W_10'(HALF_10 - 1);
  localparam logic [W_400-1:0] LAST_400 = W_400'(HALF_400 - 1);

  // A fractional half period would silently skew the output frequency, so refuse it.
  if (HALF_10 == 0 || (CLK_FREQ_HZ % (2 * FAST_FREQ_HZ)) != 0) begin : g_bad_half_10
    $fatal(1, "slow_clock: CLK_FREQ_HZ/(2*FAST_FREQ_HZ) must be a non-zero integer");
  end
  if (HALF_400 == 0 || (CLK_FREQ_HZ % (2 * SCL_FREQ_HZ)) != 0) begin : g_bad_half_400
    $fatal(1, "slow_clock: CLK_FREQ_HZ/(2*SCL_FREQ_HZ) must be a non-zero integer");
  end

  logic [W_10-1:0]  cnt_10_d,  cnt_10_q;
  logic [W_400-1:0] cnt_400_d, cnt_400_q;
  logic             clk_10_d,  clk_10_q;
  logic             clk_400_d, clk_400_q;
  logic             tick_10_d, tick_10_q;
  logic             tick_400_d, tick_400_q;

  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    cnt_10_d   = cnt_10_q + W_10'(1);
    clk_10_d   = clk_10_q;
    tick_10_d  = 1'b0;
    if (cnt_10_q == LAST_10) begin
      cnt_10_d  = '0;
      clk_10_d  = ~clk_10_q;
      tick_10_d = ~clk_10_q;
    end
  end

  always_comb begin
    cnt_400_d  = cnt_400_q + W_400'(1);
    clk_400_d  = clk_400_q;
    tick_400_d = 1'b0;
    if (cnt_400_q == LAST_400) begin
      cnt_400_d  = '0;
      clk_400_d  = ~clk_400_q;
      tick_400_d = ~clk_400_q;
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is asynchronous so outputs clear without clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_10_q   <= '0;
      cnt_400_q  <= '0;
      clk_10_q   <= 1'b0;
      clk_400_q  <= 1'b0;
      tick_10_q  <= 1'b0;
      tick_400_q <= 1'b0;
    end else begin
      cnt_10_q   <= cnt_10_d;
      cnt_400_q  <= cnt_400_d;
      clk_10_q   <= clk_10_d;
      clk_400_q  <= clk_400_d;
      tick_10_q  <= tick_10_d;
      tick_400_q <= tick_400_d;
    end
  end

  assign clk_10  = clk_10_q;
  assign clk_400 = clk_400_q;

`ifdef SLOW_CLOCK_TICK_EN
  assign tick_10  = tick_10_q;
  assign tick_400 = tick_400_q;
`else
  // Tick flops have no load in this build and are trimmed by synthesis.
  logic unused_ticks;
  assign unused_ticks = tick_10_q ^ tick_400_q;
`endif

endmodule

// File: tb/tb_slow_clock.sv
// Directed self-checking bench for slow_clock: reset behaviour, output waveforms
// over 20 us, mid-period reset, and (with SLOW_CLOCK_TICK_EN) the tick pulses.
`timescale 1ns/1ps
module tb_slow_clock;

  logic clk;
  logic rst_n;
  logic clk_400;
  logic clk_10;
`ifdef SLOW_CLOCK_TICK_EN
  logic tick_10;
  logic tick_400;
`endif

  int n_pass  = 0;
  int n_total = 0;

  longint rise_10, fall_10, rise_400, fall_400;
  longint t_rel;
  bit     found;

  slow_clock dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_400 (clk_400),
    .clk_10  (clk_10)
`ifdef SLOW_CLOCK_TICK_EN
    ,
    .tick_10 (tick_10),
    .tick_400(tick_400)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100_000;
    $display("FAIL watchdog: observed simulation still running, required finish before 100 us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_time(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed %0d ns expected %0d ns", tag, obs, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_clk_10"},  clk_10,  1'b0);
    check({tag, "_clk_400"}, clk_400, 1'b0);
`ifdef SLOW_CLOCK_TICK_EN
    check({tag, "_tick_10"},  tick_10,  1'b0);
    check({tag, "_tick_400"}, tick_400, 1'b0);
`endif
  endtask

  // After edge n since release, each output is floor(n/HALF) mod 2 (HALF = 5 and 125),
  // and a tick is high only in the cycle that output rose.
  task automatic run_edges(input string tag, input int n_edges);
    rise_10 = -1; fall_10 = -1; rise_400 = -1; fall_400 = -1;
    for (int n = 1; n <= n_edges; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_clk_10_e%0d", tag, n),  clk_10,  logic'((n / 5) % 2));
      check($sformatf("%s_clk_400_e%0d", tag, n), clk_400, logic'((n / 125) % 2));
`ifdef SLOW_CLOCK_TICK_EN
      check($sformatf("%s_tick_10_e%0d", tag, n),  tick_10,  logic'(n % 10 == 5));
      check($sformatf("%s_tick_400_e%0d", tag, n), tick_400, logic'(n % 250 == 125));
`endif
      if (clk_10 === 1'b1 && rise_10 < 0) rise_10 = $time - 1;
      if (clk_10 === 1'b0 && rise_10 >= 0 && fall_10 < 0) fall_10 = $time - 1;
      if (clk_400 === 1'b1 && rise_400 < 0) rise_400 = $time - 1;
      if (clk_400 === 1'b0 && rise_400 >= 0 && fall_400 < 0) fall_400 = $time - 1;
    end
  endtask

  initial begin
    rst_n = 1'b1;

    // First reset: low from 110 ns to 140 ns.
    #110;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_assert");
    #10;
    check_reset_state("rst_121");
    #10;
    check_reset_state("rst_131");
    #9;
    rst_n = 1'b1;

    // 2000 edges after release covers 145 ns .. 20135 ns.
    run_edges("run", 2000);
    check_time("clk_10_first_rise",  rise_10,  185);
    check_time("clk_10_first_fall",  fall_10,  235);
    check_time("clk_400_first_rise", rise_400, 1385);
    check_time("clk_400_first_fall", fall_400, 2635);

    // Advance to a cycle where both outputs are high, then reset mid-period.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk);
      #1;
      if (clk_10 === 1'b1 && clk_400 === 1'b1) found = 1'b1;
    end
    check("both_high_found", found, 1'b1);

    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst_assert");
    #10;
    check_reset_state("mid_rst_hold_a");
    #10;
    check_reset_state("mid_rst_hold_b");
    #9;
    rst_n = 1'b1;
    t_rel = $time;

    // Release lands 1 ns after an edge, so the first counted edge is 9 ns later.
    run_edges("post", 260);
    check_time("post_clk_10_first_rise",  rise_10,  t_rel + 9 + 40);
    check_time("post_clk_400_first_rise", rise_400, t_rel + 9 + 1240);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/slow_clock.md
SLOW_CLOCK -- requirements
Module: slow_clock

Interface
REQ-001 SHALL be parameterised: CLK_FREQ_HZ, 100_000_000, input clock frequency.
REQ-002 SHALL be parameterised: FAST_FREQ_HZ, 10_000_000, clk_10 output frequency.
REQ-003 SHALL be parameterised: SCL_FREQ_HZ, 400_000, clk_400 output frequency (I2C fast-mode rate).
REQ-004 SHALL have port: clk  input  1  system clock; the single clock of the block.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: clk_400  output  1  divided clock at SCL_FREQ_HZ, 50% duty.
REQ-007 SHALL have port: clk_10  output  1  divided clock at FAST_FREQ_HZ, 50% duty.

Function
REQ-008 SHALL derive half-period counts: HALF_10 = CLK_FREQ_HZ/(2*FAST_FREQ_HZ), 5 by default; HALF_400 = CLK_FREQ_HZ/(2*SCL_FREQ_HZ), 125 by default.
REQ-009 SHALL fail elaboration with a fatal message if either half-period count is zero or not an exact integer.
REQ-010 SHALL size each counter as $clog2(HALF) bits, minimum 1 bit.
REQ-011 SHALL keep an independent counter per output, incremented on every rising clk edge.
REQ-012 SHALL, on the edge where a counter equals HALF-1, wrap that counter to 0 and toggle the associated output on the same edge.
REQ-013 SHALL drive both outputs directly from flip-flops, with no combinational gating.
REQ-014 SHALL produce clk_10 as HALF_10 cycles high then HALF_10 cycles low: period 10 clk cycles by default.
REQ-015 SHALL produce clk_400 as HALF_400 cycles high then HALF_400 cycles low: period 250 clk cycles by default.
REQ-016 SHALL raise each output first at rising clk edge number HALF after reset release (edge 1 = first rising edge with rst_n high): edge 5 for clk_10, edge 125 for clk_400.
REQ-017 SHALL keep the two outputs phase-independent; no output depends on the other counter.
REQ-018 SHALL allow outputs to be undefined before the first reset assertion.

Reset
REQ-019 SHALL, while rst_n is low, force clk_400=0, clk_10=0 and all counters=0, independent of clk.
REQ-020 SHALL apply a mid-period reset assertion immediately, truncating the current phase; counting restarts per REQ-016 after release.
REQ-021 SHALL resume counting on the first rising clk edge with rst_n high; release timing needs no synchroniser inside this block.

Configuration
REQ-022 SHALL, when SLOW_CLOCK_TICK_EN is defined, add outputs tick_10 and tick_400 (1 bit each), registered.
REQ-023 SHALL pulse each tick high for exactly one clk cycle, coincident with the cycle in which its clock output rises (0->1); reset value 0.
REQ-024 SHALL, when SLOW_CLOCK_TICK_EN is undefined, omit the tick ports and their logic entirely; clk_400/clk_10 behaviour is identical in both builds.

Verification (100 MHz clk, rising edges at 5+10k ns; rst_n low 110 ns, high 140 ns)
REQ-025 SHALL check that during 110-140 ns both outputs are 0 within one delta of rst_n falling.
REQ-026 SHALL check that clk_10 rises at 185 ns, falls at 235 ns, and repeats with a 100 ns period and 50 ns high time through 20 us.
REQ-027 SHALL check that clk_400 rises at 1385 ns, falls at 2635 ns, and has a 2500 ns period through 20 us (8 full periods).
REQ-028 SHALL check that asserting rst_n low while clk_400=1 and clk_10=1, then releasing 30 ns later, clears both immediately and gives first rises 5 and 125 edges after release.
REQ-029 SHALL check, with SLOW_CLOCK_TICK_EN defined, that tick_10 is high for exactly one cycle starting at 185 ns, tick_400 for one cycle starting at 1385 ns, and both are 0 elsewhere.
REQ-030 SHALL check that elaborating with CLK_FREQ_HZ=100_000_000 and SCL_FREQ_HZ=300_000 (non-integer half period) is rejected with a fatal error.
